// File: rtl/serial_add_sched_pkg.sv
// Shared types, defaults and the round-robin pick helper for the
// serial add scheduler.
package serial_add_sched_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} sched_state_t;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_WIDTH = 8;
  localparam int MAX_REQ   = 32;

  typedef struct packed {
    logic       found;
    logic [4:0] idx;
  } rr_pick_t;

  // First set bit of valid at or after ptr, wrapping within n requesters.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                       input logic [4:0]         ptr,
                                       input int                 n);
    rr_pick_t r;
    int       cand;
    r = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      cand = int'(ptr) + i;
      if (cand >= n) cand = cand - n;
      if (i < n && !r.found && valid[cand[4:0]]) begin
        r.found = 1'b1;
        r.idx   = cand[4:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_adder_core.sv
// One-bit serial adder; the carry survives between bits of a frame and
// is dropped on the last bit so each frame starts from zero.
module serial_adder_core (
  input  logic clk,
  input  logic rst_n,
  input  logic vld,
  input  logic a,
  input  logic b,
  input  logic last,
  output logic sum
);

  logic carry_q;
  logic carry_d;

  assign sum     = a ^ b ^ carry_q;
  assign carry_d = (a & b) | (a & carry_q) | (b & carry_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
    end else if (vld) begin
      carry_q <= last ? 1'b0 : carry_d;
    end
  end

endmodule

// File: rtl/serial_add_scheduler.sv
// Round-robin front end that feeds one shared bit-serial adder from
// N_REQ parallel requesters and returns the reassembled sum with its owner.
module serial_add_scheduler
  import serial_add_sched_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*WIDTH-1:0]   req_a,
  input  logic [N_REQ*WIDTH-1:0]   req_b,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WIDTH:0]           res_sum,
  output logic [$clog2(N_REQ)-1:0] res_id,
  output logic                     busy
);

  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = $clog2(WIDTH + 1);

  sched_state_t     state_q;
  logic [IDW-1:0]   rr_ptr_q;
  logic [IDW-1:0]   rr_ptr_d;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   sum_q;
  logic [IDW-1:0]   id_q;
  logic             res_valid_q;

  logic [MAX_REQ-1:0] valid_ext;
  rr_pick_t           pick;
  logic [IDW-1:0]     pick_id;
  logic               grant;
  logic               add_vld;
  logic               add_last;
  logic               sum_bit;
  logic [WIDTH-1:0]   a_arr [N_REQ];
  logic [WIDTH-1:0]   b_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign a_arr[g] = req_a[g*WIDTH +: WIDTH];
    assign b_arr[g] = req_b[g*WIDTH +: WIDTH];
  end

  assign valid_ext = MAX_REQ'(req_valid);
  assign pick      = rr_pick(valid_ext, 5'(rr_ptr_ctx()), N_REQ);
  assign pick_id   = IDW'(pick.idx);
  assign rr_ptr_d  = (pick.idx == 5'(N_REQ - 1)) ? '0 : IDW'(pick.idx + 5'd1);

  // Grant is gated by rst_n so req_ready also drops the moment reset asserts.
  assign grant = rst_n && (state_q == IDLE) && pick.found;

  function automatic logic [IDW-1:0] rr_ptr_ctx();
    return rr_ptr_q;
  endfunction

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = grant && (pick.idx == 5'(i));
    end
  end

  assign add_vld  = (state_q == SHIFT);
  assign add_last = add_vld && (cnt_q == CW'(WIDTH));

  serial_adder_core u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .vld   (add_vld),
    .a     (a_sh_q[0]),
    .b     (b_sh_q[0]),
    .last  (add_last),
    .sum   (sum_bit)
  );

  // Operands shift right with zero fill, so the extra bit at k=WIDTH adds 0+0+carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      id_q        <= '0;
      res_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant) begin
            a_sh_q   <= a_arr[pick_id];
            b_sh_q   <= b_arr[pick_id];
            id_q     <= pick_id;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= '0;
            state_q  <= SHIFT;
          end
        end
        SHIFT: begin
          a_sh_q <= a_sh_q >> 1;
          b_sh_q <= b_sh_q >> 1;
          sum_q  <= {sum_bit, sum_q[WIDTH:1]};
          cnt_q  <= cnt_q + CW'(1);
          if (add_last) begin
            state_q     <= DONE;
            res_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            state_q     <= IDLE;
            res_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign res_valid = res_valid_q;
  assign res_sum   = sum_q;
  assign res_id    = id_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_serial_add_scheduler.sv
// Scoreboard bench for serial_add_scheduler: expected sums are queued at
// each observed grant and popped when the matching result appears.
module tb_serial_add_scheduler;

   localparam int N = 4;
   localparam int W = 8;

   typedef struct {
      logic [W:0] sum;
      int         id;
   } exp_t;

   logic           clk = 1'b0;
   logic           rstN;
   logic [N-1:0]   reqValid;
   logic [N*W-1:0] reqA;
   logic [N*W-1:0] reqB;
   logic [N-1:0]   reqReady;
   logic           resValid;
   logic           resReady;
   logic [W:0]     resSum;
   logic [1:0]     resId;
   logic           busy;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   exp_t sb[$];

   serial_add_scheduler #(.N_REQ(N), .WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rstN),
      .req_valid (reqValid),
      .req_a     (reqA),
      .req_b     (reqB),
      .req_ready (reqReady),
      .res_valid (resValid),
      .res_ready (resReady),
      .res_sum   (resSum),
      .res_id    (resId),
      .busy      (busy)
   );

   // Free-running clock and a cycle counter used for latency checks.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Present operands for one requester and raise its valid.
   task automatic applyStimulus(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
      reqA[idx*W +: W] = a;
      reqB[idx*W +: W] = b;
      reqValid[idx]    = 1'b1;
   endtask

   // Pulse reset between negedges and drop any in-flight expectations.
   task automatic applyReset();
      rstN     = 1'b0;
      reqValid = '0;
      resReady = 1'b1;
      repeat (2) @(negedge clk);
      rstN = 1'b1;
      sb.delete();
   endtask

   // Poll for a req_ready pulse; on a grant, queue the model sum for that requester.
   task automatic waitGrant(output int id, output int gcyc, output bit ok);
      ok = 1'b0; id = -1; gcyc = -1;
      for (int n = 0; n < 60 && !ok; n++) begin
         #1;
         if (reqReady !== '0) begin
            ok   = 1'b1;
            gcyc = cyc;
            for (int i = 0; i < N; i++) if (reqReady[i] === 1'b1) id = i;
            if (id >= 0)
               sb.push_back('{sum: {1'b0, reqA[id*W +: W]} + {1'b0, reqB[id*W +: W]}, id: id});
         end else begin
            @(negedge clk);
         end
      end
      if (!ok) begin
         checks++; errors++;
         $display("[TB] FAIL grant_timeout got no req_ready want a grant by cycle %0d", cyc);
      end
   endtask

   // Poll for res_valid and pop the matching expectation from the scoreboard.
   task automatic waitResult(output logic [W:0] s, output int rid, output int rcyc, output exp_t e);
      bit ok;
      ok = 1'b0; s = 'x; rid = -1; rcyc = -1;
      for (int n = 0; n < 60 && !ok; n++) begin
         #1;
         if (resValid === 1'b1) begin
            ok = 1'b1; s = resSum; rid = int'(resId); rcyc = cyc;
         end else begin
            @(negedge clk);
         end
      end
      if (sb.size() > 0) e = sb.pop_front();
      else e = '{sum: 'x, id: -2};
      if (!ok) begin
         checks++; errors++;
         $display("[TB] FAIL result_timeout got no res_valid want result by cycle %0d", cyc);
      end
   endtask

   task automatic test_reset();
      rstN = 1'b0; reqValid = '1; resReady = 1'b0; reqA = '0; reqB = '0;
      @(negedge clk); #1;
      checks++; if (reqReady !== '0) begin errors++; $display("[TB] FAIL rst_req_ready got %b want 0", reqReady); end
      checks++; if (resValid !== 1'b0) begin errors++; $display("[TB] FAIL rst_res_valid got %b want 0", resValid); end
      checks++; if (resSum !== '0) begin errors++; $display("[TB] FAIL rst_res_sum got %h want 0", resSum); end
      checks++; if (resId !== '0) begin errors++; $display("[TB] FAIL rst_res_id got %0d want 0", resId); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy got %b want 0", busy); end
      reqValid = '0;
      @(negedge clk);
      rstN = 1'b1;
   endtask

   task automatic test_single();
      int id, t, rid, rc; bit ok; logic [W:0] s; exp_t e;
      resReady = 1'b1;
      applyStimulus(0, 8'hFF, 8'h01);
      waitGrant(id, t, ok);
      checks++; if (reqReady !== 4'b0001) begin errors++; $display("[TB] FAIL single_ready got %b want 0001", reqReady); end
      checks++; if (id !== 0) begin errors++; $display("[TB] FAIL single_grant got %0d want 0", id); end
      @(negedge clk); reqValid[0] = 1'b0; #1;
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy got %b want 1", busy); end
      waitResult(s, rid, rc, e);
      checks++; if (rc !== t + 10) begin errors++; $display("[TB] FAIL single_latency got %0d want %0d", rc, t + 10); end
      checks++; if (s !== e.sum) begin errors++; $display("[TB] FAIL single_sum got %h want %h", s, e.sum); end
      checks++; if (rid !== e.id) begin errors++; $display("[TB] FAIL single_id got %0d want %0d", rid, e.id); end
   endtask

   task automatic test_round_robin();
      int id, t, prev, rid, rc; bit ok; logic [W:0] s; exp_t e;
      applyReset();
      for (int i = 0; i < N; i++) applyStimulus(i, 8'(i), 8'(16 * i));
      prev = -1;
      for (int k = 0; k < 5; k++) begin
         waitGrant(id, t, ok);
         checks++; if (id !== k % N) begin errors++; $display("[TB] FAIL rr_order[%0d] got %0d want %0d", k, id, k % N); end
         if (k > 0) begin
            checks++; if (t - prev !== 11) begin errors++; $display("[TB] FAIL rr_spacing[%0d] got %0d want 11", k, t - prev); end
         end
         prev = t;
         waitResult(s, rid, rc, e);
         checks++; if (s !== e.sum) begin errors++; $display("[TB] FAIL rr_sum[%0d] got %h want %h", k, s, e.sum); end
         checks++; if (rid !== e.id) begin errors++; $display("[TB] FAIL rr_id[%0d] got %0d want %0d", k, rid, e.id); end
         checks++; if (rc !== t + 10) begin errors++; $display("[TB] FAIL rr_latency[%0d] got %0d want %0d", k, rc, t + 10); end
      end
      reqValid = '0;
   endtask

   task automatic test_backpressure();
      int id, t, x, rid, rc; bit ok; logic [W:0] s; exp_t e;
      applyReset();
      resReady = 1'b0;
      applyStimulus(1, 8'h5A, 8'hC3);
      waitGrant(id, t, ok);
      @(negedge clk); reqValid[1] = 1'b0;
      applyStimulus(2, 8'h33, 8'h44);
      waitResult(s, rid, rc, e);
      checks++; if (s !== e.sum) begin errors++; $display("[TB] FAIL bp_sum got %h want %h", s, e.sum); end
      checks++; if (rid !== 1) begin errors++; $display("[TB] FAIL bp_id got %0d want 1", rid); end
      for (int c = 0; c < 20; c++) begin
         @(negedge clk); #1;
         checks++;
         if (resValid !== 1'b1 || resSum !== e.sum || int'(resId) !== e.id || reqReady !== '0) begin
            errors++;
            $display("[TB] FAIL bp_hold[%0d] got v=%b s=%h id=%0d rdy=%b want v=1 s=%h id=%0d rdy=0",
                     c, resValid, resSum, resId, reqReady, e.sum, e.id);
         end
      end
      resReady = 1'b1; x = cyc;
      waitGrant(id, t, ok);
      checks++; if (id !== 2) begin errors++; $display("[TB] FAIL bp_next_grant got %0d want 2", id); end
      checks++; if (t !== x + 1) begin errors++; $display("[TB] FAIL bp_next_cycle got %0d want %0d", t, x + 1); end
      @(negedge clk); reqValid[2] = 1'b0;
      waitResult(s, rid, rc, e);
      checks++; if (s !== e.sum) begin errors++; $display("[TB] FAIL bp_next_sum got %h want %h", s, e.sum); end
      checks++; if (rid !== e.id) begin errors++; $display("[TB] FAIL bp_next_id got %0d want %0d", rid, e.id); end
   endtask

   task automatic test_back_to_back();
      int id, t, t1, rid, rc; bit ok; logic [W:0] s; exp_t e;
      resReady = 1'b1;
      applyStimulus(0, 8'h80, 8'h80);
      waitGrant(id, t1, ok);
      @(negedge clk); reqValid[0] = 1'b0;
      waitResult(s, rid, rc, e);
      checks++; if (s !== e.sum) begin errors++; $display("[TB] FAIL b2b_first_sum got %h want %h", s, e.sum); end
      applyStimulus(0, 8'h00, 8'h00);
      waitGrant(id, t, ok);
      checks++; if (t - t1 !== 11) begin errors++; $display("[TB] FAIL b2b_spacing got %0d want 11", t - t1); end
      @(negedge clk); reqValid[0] = 1'b0;
      waitResult(s, rid, rc, e);
      checks++; if (s !== e.sum) begin errors++; $display("[TB] FAIL b2b_second_sum got %h want %h", s, e.sum); end
      checks++; if (rid !== 0) begin errors++; $display("[TB] FAIL b2b_second_id got %0d want 0", rid); end
   endtask

   task automatic test_reset_midshift();
      int id, t, rid, rc, seen; bit ok; logic [W:0] s; exp_t e;
      resReady = 1'b1;
      applyStimulus(1, 8'h11, 8'h22);
      waitGrant(id, t, ok);
      repeat (4) @(negedge clk);
      rstN = 1'b0; #1;
      checks++; if (busy !== 1'b0 || resValid !== 1'b0 || reqReady !== '0 || resSum !== '0) begin
         errors++; $display("[TB] FAIL midrst_outputs got busy=%b v=%b rdy=%b s=%h want all 0", busy, resValid, reqReady, resSum);
      end
      sb.delete(); reqValid = '0;
      @(negedge clk); rstN = 1'b1;
      seen = 0;
      for (int c = 0; c < 12; c++) begin @(negedge clk); #1; if (resValid !== 1'b0) seen++; end
      checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL midrst_no_result got %0d valid cycles want 0", seen); end
      applyStimulus(0, 8'h01, 8'h01);
      applyStimulus(2, 8'h7F, 8'h81);
      waitGrant(id, t, ok);
      checks++; if (id !== 0) begin errors++; $display("[TB] FAIL midrst_ptr got %0d want 0", id); end
      @(negedge clk); reqValid[0] = 1'b0;
      waitResult(s, rid, rc, e);
      waitGrant(id, t, ok);
      checks++; if (id !== 2) begin errors++; $display("[TB] FAIL midrst_req2_grant got %0d want 2", id); end
      @(negedge clk); reqValid[2] = 1'b0;
      waitResult(s, rid, rc, e);
      checks++; if (s !== e.sum) begin errors++; $display("[TB] FAIL midrst_req2_sum got %h want %h", s, e.sum); end
      checks++; if (rid !== 2) begin errors++; $display("[TB] FAIL midrst_req2_id got %0d want 2", rid); end
   endtask

   task automatic test_rr_skip();
      int id, t, rid, rc; bit ok; logic [W:0] s; exp_t e;
      applyReset();
      applyStimulus(1, 8'h01, 8'h02);
      waitGrant(id, t, ok);
      @(negedge clk); reqValid[1] = 1'b0;
      waitResult(s, rid, rc, e);
      applyStimulus(1, 8'hA0, 8'h0B);
      applyStimulus(3, 8'hF0, 8'h20);
      waitGrant(id, t, ok);
      checks++; if (id !== 3) begin errors++; $display("[TB] FAIL skip_first got %0d want 3", id); end
      @(negedge clk); reqValid[3] = 1'b0;
      waitResult(s, rid, rc, e);
      checks++; if (s !== e.sum || rid !== 3) begin errors++; $display("[TB] FAIL skip_first_result got %h/%0d want %h/3", s, rid, e.sum); end
      waitGrant(id, t, ok);
      checks++; if (id !== 1) begin errors++; $display("[TB] FAIL skip_second got %0d want 1", id); end
      @(negedge clk); reqValid[1] = 1'b0;
      waitResult(s, rid, rc, e);
      checks++; if (s !== e.sum || rid !== 1) begin errors++; $display("[TB] FAIL skip_second_result got %h/%0d want %h/1", s, rid, e.sum); end
   endtask

   // Top-level sequence of scenarios followed by the summary line.
   initial begin
      $display("[TB] start");
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_back_to_back();
      test_reset_midshift();
      test_rr_skip();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Last-resort guard in case a scenario stalls outside its own bounds.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog got no finish want finish by 200000");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
